// File: rtl/fixed_mish_lane_scheduler.sv
// Lane scheduler for a shared mish unit. One N-element beat is accepted,
// its elements are issued to the shared unit one per cycle, and the results
// are gathered by lane index into a registered output beat.
module fixed_mish_lane_scheduler #(
    parameter int unsigned DATA_IN_0_PRECISION_0  = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1  = 4,
    parameter int unsigned DATA_OUT_0_PRECISION_0 = 8,
    parameter int unsigned DATA_OUT_0_PRECISION_1 = 4,
    parameter int unsigned PARALLELISM            = 4,
    parameter int unsigned LUT_LATENCY            = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [PARALLELISM],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [PARALLELISM],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic [DATA_IN_0_PRECISION_0-1:0]  lut_data_in,
    output logic                              lut_issue,
    input  logic [DATA_OUT_0_PRECISION_0-1:0] lut_data_out,
    output logic                              busy
);

    localparam int unsigned IDX_W = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PARALLELISM - 1);

    // Fractional widths are carried for the surrounding datapath only;
    // reject configurations that cannot describe a fixed-point format.
    if (PARALLELISM < 1) begin : g_bad_par
        $error("PARALLELISM must be at least 1");
    end
    if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_in_frac
        $error("input fractional bits exceed input width");
    end
    if (DATA_OUT_0_PRECISION_1 > DATA_OUT_0_PRECISION_0) begin : g_bad_out_frac
        $error("output fractional bits exceed output width");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [DATA_IN_0_PRECISION_0-1:0]  r_in_buf  [PARALLELISM];
    logic [DATA_OUT_0_PRECISION_0-1:0] r_out_buf [PARALLELISM];
    logic [IDX_W-1:0]                  r_issue_idx;
    logic                              w_issue;
    logic                              w_capture;
    logic                              w_ret_valid;
    logic [IDX_W-1:0]                  w_ret_idx;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_issue          = 1'b0;
        w_capture        = 1'b0;
        data_in_0_ready  = 1'b0;
        data_out_0_valid = 1'b0;
        busy             = 1'b1;
        case (r_state)
            S_IDLE: begin
                data_in_0_ready = 1'b1;
                busy            = 1'b0;
                if (data_in_0_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue = 1'b1;
                if (r_issue_idx == LAST_IDX) begin
                    // With zero latency the last result lands during this
                    // cycle, so there is nothing left to drain.
                    w_state_nxt = (LUT_LATENCY == 0) ? S_OUTPUT : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_ret_valid && (w_ret_idx == LAST_IDX)) begin
                    w_state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                data_out_0_valid = 1'b1;
                if (data_out_0_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign lut_issue   = w_issue;
    assign lut_data_in = w_issue ? r_in_buf[r_issue_idx] : '0;

    // Input capture and issue index sequencing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_idx <= '0;
            for (int unsigned i = 0; i < PARALLELISM; i++) begin
                r_in_buf[i] <= '0;
            end
        end else if (w_capture) begin
            r_issue_idx <= '0;
            r_in_buf    <= data_in_0;
        end else if (w_issue) begin
            r_issue_idx <= (r_issue_idx == LAST_IDX) ? '0 : r_issue_idx + IDX_W'(1);
        end
    end

    // Return tracking: the lane index travels alongside the shared unit's
    // pipeline so each result is written to the lane it was issued from.
    if (LUT_LATENCY == 0) begin : g_no_dl
        assign w_ret_valid = w_issue;
        assign w_ret_idx   = r_issue_idx;
    end else begin : g_dl
        logic             r_dl_valid [LUT_LATENCY];
        logic [IDX_W-1:0] r_dl_idx   [LUT_LATENCY];

        // Delay line of (valid, index) matching the shared-unit latency
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int unsigned i = 0; i < LUT_LATENCY; i++) begin
                    r_dl_valid[i] <= 1'b0;
                    r_dl_idx[i]   <= '0;
                end
            end else begin
                r_dl_valid[0] <= w_issue;
                r_dl_idx[0]   <= r_issue_idx;
                for (int unsigned i = 1; i < LUT_LATENCY; i++) begin
                    r_dl_valid[i] <= r_dl_valid[i-1];
                    r_dl_idx[i]   <= r_dl_idx[i-1];
                end
            end
        end

        assign w_ret_valid = r_dl_valid[LUT_LATENCY-1];
        assign w_ret_idx   = r_dl_idx[LUT_LATENCY-1];
    end

    // Result collection into the registered output beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PARALLELISM; i++) begin
                r_out_buf[i] <= '0;
            end
        end else if (w_ret_valid) begin
            r_out_buf[w_ret_idx] <= lut_data_out;
        end
    end

    assign data_out_0 = r_out_buf;

endmodule

// File: tb/tb_fixed_mish_lane_scheduler.sv
// Directed bench for fixed_mish_lane_scheduler: a latency-2 instance and a
// latency-0 instance, each with a shared-unit stub computing f(x) = ~x.
module tb_fixed_mish_lane_scheduler;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance with L = 2
    logic [7:0] din  [N];
    logic [7:0] dout [N];
    logic       din_valid, din_ready, dout_valid, dout_ready;
    logic [7:0] lut_in, lut_out;
    logic       lut_issue, busy;
    logic [7:0] stub_d1, stub_d2;

    always @(posedge clk) begin
        stub_d1 <= ~lut_in;
        stub_d2 <= stub_d1;
    end
    assign lut_out = stub_d2;

    fixed_mish_lane_scheduler #(
        .DATA_IN_0_PRECISION_0 (8),
        .DATA_IN_0_PRECISION_1 (4),
        .DATA_OUT_0_PRECISION_0(8),
        .DATA_OUT_0_PRECISION_1(4),
        .PARALLELISM           (N),
        .LUT_LATENCY           (2)
    ) dut (
        .clk             (clk),
        .rst             (rst_n),
        .data_in_0       (din),
        .data_in_0_valid (din_valid),
        .data_in_0_ready (din_ready),
        .data_out_0      (dout),
        .data_out_0_valid(dout_valid),
        .data_out_0_ready(dout_ready),
        .lut_data_in     (lut_in),
        .lut_issue       (lut_issue),
        .lut_data_out    (lut_out),
        .busy            (busy)
    );

    // Instance with L = 0
    logic [7:0] din0  [N];
    logic [7:0] dout0 [N];
    logic       din_valid0, din_ready0, dout_valid0, dout_ready0;
    logic [7:0] lut_in0, lut_out0;
    logic       lut_issue0, busy0;

    assign lut_out0 = ~lut_in0;

    fixed_mish_lane_scheduler #(
        .DATA_IN_0_PRECISION_0 (8),
        .DATA_IN_0_PRECISION_1 (4),
        .DATA_OUT_0_PRECISION_0(8),
        .DATA_OUT_0_PRECISION_1(4),
        .PARALLELISM           (N),
        .LUT_LATENCY           (0)
    ) dut0 (
        .clk             (clk),
        .rst             (rst_n),
        .data_in_0       (din0),
        .data_in_0_valid (din_valid0),
        .data_in_0_ready (din_ready0),
        .data_out_0      (dout0),
        .data_out_0_valid(dout_valid0),
        .data_out_0_ready(dout_ready0),
        .lut_data_in     (lut_in0),
        .lut_issue       (lut_issue0),
        .lut_data_out    (lut_out0),
        .busy            (busy0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] a [N]);
        return {a[3], a[2], a[1], a[0]};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] v);
        for (int i = 0; i < N; i++) din[i] = v[8*i +: 8];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(din_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),       32'd0);
        check({tag, "_lut_issue"}, 32'(lut_issue),  32'd0);
        check({tag, "_lut_in"},    32'(lut_in),     32'd0);
        check({tag, "_dout"},      pack(dout),      32'd0);
    endtask

    logic [31:0] expq [$];
    int          sent;
    int          got;
    int          cyc;

    initial begin
        rst_n       = 1'b0;
        din_valid   = 1'b0;
        dout_ready  = 1'b1;
        din_valid0  = 1'b0;
        dout_ready0 = 1'b1;
        set_beat(32'h0);
        for (int i = 0; i < N; i++) din0[i] = 8'h00;

        // Reset state
        #2;
        check_reset_outputs("rst");
        step(2);
        rst_n = 1'b1;
        step(1);

        // Test 1: beat {10,20,30,40}, L=2, output valid in cycle 7
        set_beat(32'h40302010);
        din_valid = 1'b1;
        check("t1_ready_c0", 32'(din_ready), 32'd1);
        step(1);
        din_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("t1_issue",    32'(lut_issue), 32'd1);
            check("t1_lut_in",   32'(lut_in),    32'(8'h10 * (i + 1)));
            check("t1_busy",     32'(busy),      32'd1);
            check("t1_in_ready", 32'(din_ready), 32'd0);
            step(1);
        end
        check("t1_issue_c5",  32'(lut_issue),  32'd0);
        check("t1_lut_in_c5", 32'(lut_in),     32'd0);
        step(1);
        check("t1_valid_c6",  32'(dout_valid), 32'd0);
        step(1);
        check("t1_valid_c7",  32'(dout_valid), 32'd1);
        check("t1_data_c7",   pack(dout),      32'hBFCFDFEF);
        step(1);
        check("t1_valid_c8",  32'(dout_valid), 32'd0);
        check("t1_ready_c8",  32'(din_ready),  32'd1);

        // Test 2: downstream stalls for 5 cycles
        dout_ready = 1'b0;
        din_valid  = 1'b1;
        step(1);
        din_valid = 1'b0;
        step(6);
        for (int k = 0; k < 5; k++) begin
            check("t2_valid_hold", 32'(dout_valid), 32'd1);
            check("t2_data_hold",  pack(dout),      32'hBFCFDFEF);
            check("t2_in_ready",   32'(din_ready),  32'd0);
            step(1);
        end
        dout_ready = 1'b1;
        check("t2_valid_accept", 32'(dout_valid), 32'd1);
        check("t2_in_ready_acc", 32'(din_ready),  32'd0);
        step(1);
        check("t2_in_ready_after", 32'(din_ready),  32'd1);
        check("t2_valid_after",    32'(dout_valid), 32'd0);

        // Test 3: L=0, back-to-back with input valid held high
        din0[0] = 8'h01; din0[1] = 8'h02; din0[2] = 8'h03; din0[3] = 8'h04;
        din_valid0 = 1'b1;
        check("t3_ready_c0", 32'(din_ready0), 32'd1);
        step(1);
        din0[0] = 8'h11; din0[1] = 8'h12; din0[2] = 8'h13; din0[3] = 8'h14;
        check("t3_ready_c1",  32'(din_ready0), 32'd0);
        check("t3_issue_c1",  32'(lut_issue0), 32'd1);
        check("t3_lut_in_c1", 32'(lut_in0),    32'h01);
        step(4);
        check("t3_valid_c5",  32'(dout_valid0), 32'd1);
        check("t3_data_c5",   pack(dout0),      32'hFBFCFDFE);
        check("t3_ready_c5",  32'(din_ready0),  32'd0);
        step(1);
        check("t3_valid_c6",  32'(dout_valid0), 32'd0);
        check("t3_ready_c6",  32'(din_ready0),  32'd1);
        step(1);
        din_valid0 = 1'b0;
        check("t3_busy_c7",   32'(busy0),       32'd1);
        step(4);
        check("t3_valid_c11", 32'(dout_valid0), 32'd1);
        check("t3_data_c11",  pack(dout0),      32'hEBECEDEE);
        step(1);
        check("t3_valid_c12", 32'(dout_valid0), 32'd0);
        check("t3_busy_c12",  32'(busy0),       32'd0);

        // Test 4: reset in cycle 3 discards the beat and in-flight results
        set_beat(32'h40302010);
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
        step(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t4");
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("t4_no_valid", 32'(dout_valid), 32'd0);
            check("t4_idle",     32'(busy),       32'd0);
        end
        set_beat(32'h88776655);
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
        step(6);
        check("t4_valid_c7", 32'(dout_valid), 32'd1);
        check("t4_data_c7",  pack(dout),      32'h778899AA);
        step(1);

        // Test 6: random throttling on both sides over 1000 beats
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 1000 && cyc < 40000) begin
            din_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) din[i] = 8'($urandom);
            dout_ready = ($urandom_range(0, 2) != 0);
            if (din_valid && din_ready) begin
                expq.push_back(~pack(din));
                sent++;
            end
            if (dout_valid && dout_ready) begin
                check("rnd_have_expected", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) check("rnd_beat", pack(dout), expq.pop_front());
                got++;
            end
            step(1);
            cyc++;
        end
        din_valid = 1'b0;
        check("rnd_received", 32'(got),         32'd1000);
        check("rnd_sent",     32'(sent),        32'd1000);
        check("rnd_leftover", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
